gray_counter_param: RTL and testbench

Parametrised, registered Gray-code counter; the next generation of the team's 8-bit Gray counter. Adds width parameter, count enable, up/down direction, synchronous load, wrap/saturate mode and status flags. Gray output comes directly from flops, so it is glitch-free and safe to pass to a two-flop synchroniser in another clock domain (FIFO pointers, position encoders).

---
 rtl/gray_pkg.sv | 47 ++++
 rtl/gray_counter_param_if.sv | 42 ++++
 rtl/gray2bin_conv.sv | 23 ++
 rtl/gray_counter_param.sv | 108 ++++++++++
 tb/tb_gray_counter_param.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and constants for the Gray counter and the Gray-pointer FIFO.
// Functions operate on 32-bit containers and mask to the requested width.
package gray_pkg;

  localparam int MAX_WIDTH = 32;
  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_LOAD = 2'd1,
    OP_INC  = 2'd2,
    OP_DEC  = 2'd3
  } op_e;

  function automatic logic [31:0] width_mask(input int width);
    logic [31:0] mask;
    if (width >= MAX_WIDTH) begin
      mask = '1;
    end else begin
      mask = (32'd1 << width) - 32'd1;
    end
    return mask;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin, input int width);
    logic [31:0] b;
    b = bin & width_mask(width);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; bits above the width are masked to zero first.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray, input int width);
    logic [31:0] g;
    logic [31:0] b;
    logic        acc;
    g   = gray & width_mask(width);
    b   = '0;
    acc = 1'b0;
    for (int i = MAX_WIDTH - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_param_if.sv
// Control and status bundle of the Gray counter; master drives controls, slave is the counter.
interface gray_counter_param_if #(
  parameter int WIDTH = 8
);

  // No handshake: en, up and load are level-qualified and sampled on every rising clk edge;
  // the counter never stalls, so there is no valid/ready pair.
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_gray;
  logic [WIDTH-1:0] count_gray;
  logic [WIDTH-1:0] count_bin;
  logic             wrap;
  logic             at_max;
  logic             at_min;

  modport master (
    output en,
    output up,
    output load,
    output load_gray,
    input  count_gray,
    input  count_bin,
    input  wrap,
    input  at_max,
    input  at_min
  );

  modport slave (
    input  en,
    input  up,
    input  load,
    input  load_gray,
    output count_gray,
    output count_bin,
    output wrap,
    output at_max,
    output at_min
  );

endinterface

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter: running XOR from the MSB down.
// Shared with the Gray-pointer FIFO.
module gray2bin_conv
  import gray_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  logic acc;

  always_comb begin
    bin = '0;
    acc = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ gray[i];
      bin[i] = acc;
    end
  end

endmodule

// File: rtl/gray_counter_param.sv
// Registered Gray counter with enable, direction, load, wrap/saturate mode and end flags.
// Binary and Gray registers are both loaded from the same next value each edge.
module gray_counter_param
  import gray_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          SATURATE  = MODE_WRAP,
  parameter logic [31:0] RESET_BIN = 32'd0
) (
  input  logic                  clk,
  input  logic                  reset,
  gray_counter_param_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_BIN    = '1;
  localparam logic [WIDTH-1:0] MIN_BIN    = '0;
  localparam logic [WIDTH-1:0] RESET_B    = WIDTH'(RESET_BIN);
  localparam logic [WIDTH-1:0] RESET_G    = WIDTH'(bin2gray(RESET_BIN, WIDTH));
  localparam bit               SAT_MODE   = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] bin_q;
  logic [WIDTH-1:0] gray_q;
  logic             wrap_q;

  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_next;
  op_e              op;

  gray2bin_conv #(
    .WIDTH (WIDTH)
  ) u_load_conv (
    .gray (bus.load_gray),
    .bin  (load_bin)
  );

  // Load beats count; direction is only meaningful while en is high.
  always_comb begin
    op = OP_HOLD;
    if (bus.load) begin
      op = OP_LOAD;
    end else if (bus.en) begin
      op = bus.up ? OP_INC : OP_DEC;
    end
  end

  always_comb begin
    bin_next  = bin_q;
    wrap_next = 1'b0;
    case (op)
      OP_LOAD: begin
        bin_next = load_bin;
      end
      OP_INC: begin
        if (bin_q == MAX_BIN) begin
          if (!SAT_MODE) begin
            bin_next  = MIN_BIN;
            wrap_next = 1'b1;
          end
        end else begin
          bin_next = bin_q + 1'b1;
        end
      end
      OP_DEC: begin
        if (bin_q == MIN_BIN) begin
          if (!SAT_MODE) begin
            bin_next  = MAX_BIN;
            wrap_next = 1'b1;
          end
        end else begin
          bin_next = bin_q - 1'b1;
        end
      end
      default: begin
        bin_next = bin_q;
      end
    endcase
  end

  // A loaded Gray value goes straight into the Gray register so it is never re-encoded.
  always_comb begin
    if (op == OP_LOAD) begin
      gray_next = bus.load_gray;
    end else begin
      gray_next = WIDTH'(bin2gray(32'(bin_next), WIDTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bin_q  <= RESET_B;
      gray_q <= RESET_G;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_next;
      gray_q <= gray_next;
      wrap_q <= wrap_next;
    end
  end

  assign bus.count_gray = gray_q;
  assign bus.count_bin  = bin_q;
  assign bus.wrap       = wrap_q;
  assign bus.at_max     = (bin_q == MAX_BIN);
  assign bus.at_min     = (bin_q == MIN_BIN);

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param: four configurations checked every cycle against an arithmetic
// model, plus hand-computed literal expectations at the interesting points.
module tb_gray_counter_param;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the three 8-bit instances, separate stimulus for the 4-bit one.
  logic       rst8, ld8, en8, up8;
  logic [7:0] lg8;
  logic       rst4, ld4, en4, up4;
  logic [3:0] lg4;

  gray_counter_param_if #(.WIDTH(8)) if0 ();
  gray_counter_param_if #(.WIDTH(8)) if1 ();
  gray_counter_param_if #(.WIDTH(8)) if2 ();
  gray_counter_param_if #(.WIDTH(4)) if3 ();

  assign if0.en = en8;  assign if0.up = up8;  assign if0.load = ld8;  assign if0.load_gray = lg8;
  assign if1.en = en8;  assign if1.up = up8;  assign if1.load = ld8;  assign if1.load_gray = lg8;
  assign if2.en = en8;  assign if2.up = up8;  assign if2.load = ld8;  assign if2.load_gray = lg8;
  assign if3.en = en4;  assign if3.up = up4;  assign if3.load = ld4;  assign if3.load_gray = lg4;

  gray_counter_param #(.WIDTH(8), .SATURATE(0), .RESET_BIN(32'd0)) u_wrap8 (
    .clk (clk), .reset (rst8), .bus (if0));
  gray_counter_param #(.WIDTH(8), .SATURATE(1), .RESET_BIN(32'd0)) u_sat8 (
    .clk (clk), .reset (rst8), .bus (if1));
  gray_counter_param #(.WIDTH(8), .SATURATE(0), .RESET_BIN(32'd3)) u_rb3 (
    .clk (clk), .reset (rst8), .bus (if2));
  gray_counter_param #(.WIDTH(4), .SATURATE(0), .RESET_BIN(32'd0)) u_wrap4 (
    .clk (clk), .reset (rst4), .bus (if3));

  logic [63:0] a_gray [4];
  logic [63:0] a_bin  [4];
  logic        a_wrap [4];
  logic        a_max  [4];
  logic        a_min  [4];

  assign a_gray[0] = 64'(if0.count_gray); assign a_bin[0] = 64'(if0.count_bin);
  assign a_gray[1] = 64'(if1.count_gray); assign a_bin[1] = 64'(if1.count_bin);
  assign a_gray[2] = 64'(if2.count_gray); assign a_bin[2] = 64'(if2.count_bin);
  assign a_gray[3] = 64'(if3.count_gray); assign a_bin[3] = 64'(if3.count_bin);
  assign a_wrap[0] = if0.wrap; assign a_max[0] = if0.at_max; assign a_min[0] = if0.at_min;
  assign a_wrap[1] = if1.wrap; assign a_max[1] = if1.at_max; assign a_min[1] = if1.at_min;
  assign a_wrap[2] = if2.wrap; assign a_max[2] = if2.at_max; assign a_min[2] = if2.at_min;
  assign a_wrap[3] = if3.wrap; assign a_max[3] = if3.at_max; assign a_min[3] = if3.at_min;

  int p_w   [4] = '{8, 8, 8, 4};
  bit p_sat [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  int p_rb  [4] = '{0, 0, 3, 0};

  // Scoreboard state: expected count, wrap pulse, and whether the last edge was a Gray step.
  longint m_bin    [4];
  bit     m_wrap   [4];
  bit     m_valid  [4];
  bit     m_onebit [4];
  logic [63:0] prev_gray [4];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0h required=%0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  // Decode by search: the binary value whose Gray image is g.
  function automatic longint gray_decode(input longint g, input int w);
    for (longint b = 0; b < (longint'(1) << w); b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      bit     r, l, e, u;
      longint g, maxv;
      if (i < 3) begin
        r = rst8; l = ld8; e = en8; u = up8; g = longint'(lg8);
      end else begin
        r = rst4; l = ld4; e = en4; u = up4; g = longint'(lg4);
      end
      maxv = (longint'(1) << p_w[i]) - 1;
      m_wrap[i]   = 1'b0;
      m_onebit[i] = 1'b0;
      if (!r) begin
        m_bin[i]   = p_rb[i];
        m_valid[i] = 1'b1;
      end else if (l) begin
        m_bin[i] = gray_decode(g, p_w[i]);
      end else if (e) begin
        if (u && m_bin[i] == maxv) begin
          if (!p_sat[i]) begin
            m_bin[i] = 0; m_wrap[i] = 1'b1; m_onebit[i] = 1'b1;
          end
        end else if (!u && m_bin[i] == 0) begin
          if (!p_sat[i]) begin
            m_bin[i] = maxv; m_wrap[i] = 1'b1; m_onebit[i] = 1'b1;
          end
        end else begin
          m_bin[i]    = u ? m_bin[i] + 1 : m_bin[i] - 1;
          m_onebit[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i]) begin
        longint eb, maxv;
        eb   = m_bin[i];
        maxv = (longint'(1) << p_w[i]) - 1;
        check("count_bin", i, a_bin[i], 64'(eb));
        check("count_gray", i, a_gray[i], 64'(eb ^ (eb >> 1)));
        check("gray_of_bin", i, a_gray[i], a_bin[i] ^ (a_bin[i] >> 1));
        check("wrap", i, 64'(a_wrap[i]), 64'(m_wrap[i]));
        check("at_max", i, 64'(a_max[i]), 64'(eb == maxv));
        check("at_min", i, 64'(a_min[i]), 64'(eb == 0));
        if (m_onebit[i]) begin
          check("one_bit_step", i, 64'($countones(a_gray[i] ^ prev_gray[i])), 64'd1);
        end
        prev_gray[i] = a_gray[i];
      end
    end
  end

  task automatic drive8(input bit r, input bit l, input logic [7:0] g, input bit e, input bit u);
    rst8 = r; ld8 = l; lg8 = g; en8 = e; up8 = u;
    @(negedge clk);
  endtask

  task automatic drive4(input bit r, input bit l, input logic [3:0] g, input bit e, input bit u);
    rst4 = r; ld4 = l; lg4 = g; en4 = e; up4 = u;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_bin[i] = 0; m_wrap[i] = 0; m_valid[i] = 0; m_onebit[i] = 0; prev_gray[i] = '0;
    end
    rst4 = 1'b0; ld4 = 1'b0; lg4 = '0; en4 = 1'b0; up4 = 1'b0;

    drive8(0, 0, 8'h00, 0, 0);
    drive8(0, 0, 8'h00, 0, 0);
    check("lit_reset_gray", 0, a_gray[0], 64'h00);
    check("lit_reset_min", 0, 64'(a_min[0]), 64'd1);
    check("lit_reset_rb3_gray", 2, a_gray[2], 64'h02);
    check("lit_reset_rb3_bin", 2, a_bin[2], 64'h03);

    for (int k = 1; k <= 256; k++) begin
      drive8(1, 0, 8'h00, 1, 1);
      if (k == 255) begin
        check("lit_max_gray", 0, a_gray[0], 64'h80);
        check("lit_max_flag", 0, 64'(a_max[0]), 64'd1);
      end
    end
    check("lit_wrap_gray", 0, a_gray[0], 64'h00);
    check("lit_wrap_pulse", 0, 64'(a_wrap[0]), 64'd1);
    check("lit_sat_top_hold", 1, a_bin[1], 64'hFF);

    drive8(1, 0, 8'h00, 1, 0);
    check("lit_down_bin", 0, a_bin[0], 64'hFF);
    check("lit_down_gray", 0, a_gray[0], 64'h80);
    check("lit_down_wrap", 0, 64'(a_wrap[0]), 64'd1);
    drive8(1, 0, 8'h00, 0, 0);
    check("lit_hold_bin", 0, a_bin[0], 64'hFF);
    check("lit_hold_wrap", 0, 64'(a_wrap[0]), 64'd0);

    drive8(1, 1, 8'h07, 1, 1);
    check("lit_load_bin", 0, a_bin[0], 64'h05);
    check("lit_load_gray", 0, a_gray[0], 64'h07);
    check("lit_load_wrap", 0, 64'(a_wrap[0]), 64'd0);

    drive8(1, 1, 8'h80, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive8(1, 0, 8'h00, 1, 1);
      check("lit_sat_hold_bin", 1, a_bin[1], 64'hFF);
      check("lit_sat_no_wrap", 1, 64'(a_wrap[1]), 64'd0);
    end
    drive8(1, 0, 8'h00, 1, 0);
    check("lit_sat_down_bin", 1, a_bin[1], 64'hFE);
    check("lit_sat_down_gray", 1, a_gray[1], 64'h81);

    drive8(1, 1, 8'h60, 0, 0);
    check("lit_mid_bin", 0, a_bin[0], 64'h40);
    drive8(0, 1, 8'h55, 1, 1);
    check("lit_rst_pri_gray", 0, a_gray[0], 64'h00);
    check("lit_rst_pri_wrap", 0, 64'(a_wrap[0]), 64'd0);
    check("lit_rst_pri_rb3", 2, a_gray[2], 64'h02);

    for (int k = 0; k < 3; k++) begin
      drive8(1, 0, 8'h00, 1, 0);
      check("lit_sat_low_hold", 1, a_bin[1], 64'h00);
    end
    for (int k = 0; k < 12; k++) drive8(1, 0, 8'h00, 1, (k % 3) != 0);
    drive8(1, 0, 8'h00, 0, 0);

    drive4(0, 0, 4'h0, 0, 0);
    check("lit_w4_reset_min", 3, 64'(a_min[3]), 64'd1);
    drive4(1, 1, 4'h8, 0, 0);
    check("lit_w4_load_bin", 3, a_bin[3], 64'h0F);
    check("lit_w4_load_max", 3, 64'(a_max[3]), 64'd1);
    drive4(1, 0, 4'h0, 1, 1);
    check("lit_w4_wrap_bin", 3, a_bin[3], 64'h00);
    check("lit_w4_wrap_pulse", 3, 64'(a_wrap[3]), 64'd1);

    for (int k = 0; k < 2000; k++) begin
      drive4($urandom_range(0, 49) != 0, $urandom_range(0, 7) == 0,
             4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
